// File: rtl/line_game_ctrl.sv
// Game-state controller for the horizontal-line obstacle game: conditions the start button
// and frame strobe, detects cube/line collisions, sequences IDLE/LOAD/PLAY/OVER and keeps score.
module line_game_ctrl #(
  parameter int unsigned FRAMES_PER_POINT = 60,
  parameter int unsigned FLASH_FRAMES     = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame,
  input  logic       btn_start,
  input  logic       cube_px,
  input  logic       hline_px,
  output logic       start_machine,
  output logic       load_counter,
  output logic       flash,
  output logic       stop,
  output logic       game_over,
  output logic [7:0] score,
  output logic [7:0] best
);

  localparam logic [7:0] PointMax = 8'(FRAMES_PER_POINT - 1);
  localparam logic [7:0] FlashMax = 8'(FLASH_FRAMES - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StPlay, StOver} state_e;

  state_e     state_q, state_d;
  logic       btn_sync1_q, btn_sync2_q, btn_prev_q, start_evt_q;
  logic       frame_q, frame_tick_q;
  logic       load_cnt_q, load_cnt_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       hit_latch_q, hit_latch_d;
  logic [7:0] flash_cnt_q, flash_cnt_d;
  logic       flash_q, flash_d;
  logic [7:0] score_q, score_d;
  logic [7:0] best_q, best_d;
  logic       start_machine_q, load_counter_q, stop_q, game_over_q;
  logic       hit;

  assign hit = cube_px & hline_px;

  always_comb begin
    state_d     = state_q;
    load_cnt_d  = load_cnt_q;
    frame_cnt_d = frame_cnt_q;
    hit_latch_d = hit_latch_q;
    flash_cnt_d = flash_cnt_q;
    flash_d     = flash_q;
    score_d     = score_q;
    best_d      = best_q;

    unique case (state_q)
      StIdle, StOver: begin
        if (frame_tick_q) begin
          if (flash_cnt_q == FlashMax) begin
            flash_cnt_d = 8'd0;
            flash_d     = ~flash_q;
          end else begin
            flash_cnt_d = flash_cnt_q + 8'd1;
          end
        end
        if (start_evt_q) begin
          state_d    = StLoad;
          load_cnt_d = 1'b0;
          score_d    = 8'd0;
          flash_d    = 1'b1;
        end
      end

      StLoad: begin
        flash_d = 1'b1;
        // Two ticks guarantee one complete frame with load_counter held high.
        if (frame_tick_q) begin
          if (load_cnt_q) begin
            state_d     = StPlay;
            frame_cnt_d = 8'd0;
            hit_latch_d = 1'b0;
          end else begin
            load_cnt_d = 1'b1;
          end
        end
      end

      StPlay: begin
        flash_d = 1'b1;
        if (hit) begin
          hit_latch_d = 1'b1;
        end
        if (frame_tick_q) begin
          hit_latch_d = 1'b0;
          // A collision on the scoring tick wins over the increment.
          if (hit_latch_q || hit) begin
            state_d     = StOver;
            flash_cnt_d = 8'd0;
            if (score_q > best_q) begin
              best_d = score_q;
            end
          end else if (frame_cnt_q == PointMax) begin
            frame_cnt_d = 8'd0;
            if (score_q != 8'hFF) begin
              score_d = score_q + 8'd1;
            end
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_sync1_q     <= 1'b0;
      btn_sync2_q     <= 1'b0;
      btn_prev_q      <= 1'b0;
      start_evt_q     <= 1'b0;
      frame_q         <= 1'b0;
      frame_tick_q    <= 1'b0;
      state_q         <= StIdle;
      load_cnt_q      <= 1'b0;
      frame_cnt_q     <= 8'd0;
      hit_latch_q     <= 1'b0;
      flash_cnt_q     <= 8'd0;
      flash_q         <= 1'b0;
      score_q         <= 8'd0;
      best_q          <= 8'd0;
      start_machine_q <= 1'b0;
      load_counter_q  <= 1'b1;
      stop_q          <= 1'b0;
      game_over_q     <= 1'b0;
    end else begin
      btn_sync1_q     <= btn_start;
      btn_sync2_q     <= btn_sync1_q;
      btn_prev_q      <= btn_sync2_q;
      start_evt_q     <= btn_sync2_q & ~btn_prev_q;
      frame_q         <= frame;
      frame_tick_q    <= frame & ~frame_q;
      state_q         <= state_d;
      load_cnt_q      <= load_cnt_d;
      frame_cnt_q     <= frame_cnt_d;
      hit_latch_q     <= hit_latch_d;
      flash_cnt_q     <= flash_cnt_d;
      flash_q         <= flash_d;
      score_q         <= score_d;
      best_q          <= best_d;
      // Decoded from next state so outputs switch on the same edge as the state.
      start_machine_q <= (state_d == StPlay);
      load_counter_q  <= (state_d == StIdle) || (state_d == StLoad);
      stop_q          <= (state_d == StPlay);
      game_over_q     <= (state_d == StOver);
    end
  end

  assign start_machine = start_machine_q;
  assign load_counter  = load_counter_q;
  assign flash         = flash_q;
  assign stop          = stop_q;
  assign game_over     = game_over_q;
  assign score         = score_q;
  assign best          = best_q;

endmodule

// File: tb/tb_line_game_ctrl.sv
// Directed bench for line_game_ctrl: default build plus a one-frame-per-point build sharing
// the same stimulus, used for the score saturation case.
module tb_line_game_ctrl;

  logic       clk = 1'b0;
  logic       reset, frame, btn_start, cube_px, hline_px;
  logic       start_machine, load_counter, flash, stop, game_over;
  logic [7:0] score, best;
  logic       f_start_machine, f_load_counter, f_flash, f_stop, f_game_over;
  logic [7:0] f_score, f_best;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  line_game_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .frame        (frame),
    .btn_start    (btn_start),
    .cube_px      (cube_px),
    .hline_px     (hline_px),
    .start_machine(start_machine),
    .load_counter (load_counter),
    .flash        (flash),
    .stop         (stop),
    .game_over    (game_over),
    .score        (score),
    .best         (best)
  );

  line_game_ctrl #(
    .FRAMES_PER_POINT(1),
    .FLASH_FRAMES    (15)
  ) dut_fast (
    .clk          (clk),
    .reset        (reset),
    .frame        (frame),
    .btn_start    (btn_start),
    .cube_px      (cube_px),
    .hline_px     (hline_px),
    .start_machine(f_start_machine),
    .load_counter (f_load_counter),
    .flash        (f_flash),
    .stop         (f_stop),
    .game_over    (f_game_over),
    .score        (f_score),
    .best         (f_best)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame period: exactly one frame_tick inside the DUT.
  task automatic frame_pulse();
    frame = 1'b1;
    cycles(2);
    frame = 1'b0;
    cycles(2);
  endtask

  task automatic frames(input int n);
    repeat (n) frame_pulse();
  endtask

  initial begin
    reset     = 1'b0;
    frame     = 1'b0;
    btn_start = 1'b0;
    cube_px   = 1'b0;
    hline_px  = 1'b0;
    cycles(3);
    chk("rst_load_counter", {7'd0, load_counter}, 8'd1);
    chk("rst_start_machine", {7'd0, start_machine}, 8'd0);
    chk("rst_stop", {7'd0, stop}, 8'd0);
    chk("rst_flash", {7'd0, flash}, 8'd0);
    chk("rst_game_over", {7'd0, game_over}, 8'd0);
    chk("rst_score", score, 8'd0);
    chk("rst_best", best, 8'd0);
    reset = 1'b1;
    cycles(2);

    // Idle blink: toggles every 15 ticks
    frames(14);
    chk("idle_flash_14", {7'd0, flash}, 8'd0);
    frame_pulse();
    chk("idle_flash_15", {7'd0, flash}, 8'd1);
    frames(14);
    chk("idle_flash_29", {7'd0, flash}, 8'd1);
    frame_pulse();
    chk("idle_flash_30", {7'd0, flash}, 8'd0);
    chk("idle_load_counter", {7'd0, load_counter}, 8'd1);
    chk("idle_stop", {7'd0, stop}, 8'd0);

    // Start press: LOAD exactly three edges after first sample
    btn_start = 1'b1;
    cycles(3);
    chk("press_not_yet", {7'd0, flash}, 8'd0);
    cycles(1);
    chk("press_load_flash", {7'd0, flash}, 8'd1);
    chk("press_load_counter", {7'd0, load_counter}, 8'd1);
    btn_start = 1'b0;
    frame_pulse();
    chk("load_after_tick1", {7'd0, start_machine}, 8'd0);
    frame_pulse();
    chk("play_start_machine", {7'd0, start_machine}, 8'd1);
    chk("play_stop", {7'd0, stop}, 8'd1);
    chk("play_load_counter", {7'd0, load_counter}, 8'd0);

    frames(180);
    chk("score_180", score, 8'd3);
    chk("fast_score_180", f_score, 8'd180);
    frames(80);
    chk("score_260", score, 8'd4);
    chk("fast_score_sat", f_score, 8'd255);

    // One-cycle collision mid-frame, caught at the next tick
    cycles(1);
    cube_px  = 1'b1;
    hline_px = 1'b1;
    cycles(1);
    cube_px  = 1'b0;
    hline_px = 1'b0;
    cycles(3);
    chk("hit_latched_wait", {7'd0, game_over}, 8'd0);
    frame_pulse();
    chk("over_game_over", {7'd0, game_over}, 8'd1);
    chk("over_stop", {7'd0, stop}, 8'd0);
    chk("over_start_machine", {7'd0, start_machine}, 8'd0);
    chk("over_score", score, 8'd4);
    chk("over_best", best, 8'd4);
    chk("over_flash_held", {7'd0, flash}, 8'd1);
    chk("fast_over_best", f_best, 8'd255);
    frames(14);
    chk("over_flash_14", {7'd0, flash}, 8'd1);
    frame_pulse();
    chk("over_flash_15", {7'd0, flash}, 8'd0);

    // Game 2: button held throughout; collision on the scoring tick
    btn_start = 1'b1;
    cycles(4);
    chk("g2_load_game_over", {7'd0, game_over}, 8'd0);
    chk("g2_score_cleared", score, 8'd0);
    frames(2);
    chk("g2_play_stop", {7'd0, stop}, 8'd1);
    frames(299);
    chk("g2_score_299", score, 8'd4);
    frame    = 1'b1;
    cycles(1);
    cube_px  = 1'b1;
    hline_px = 1'b1;
    cycles(1);
    cube_px  = 1'b0;
    hline_px = 1'b0;
    frame    = 1'b0;
    cycles(2);
    chk("g2_hit_on_tick_over", {7'd0, game_over}, 8'd1);
    chk("g2_no_increment", score, 8'd4);
    chk("g2_best", best, 8'd4);
    cycles(10);
    chk("g2_held_no_restart", {7'd0, game_over}, 8'd1);
    btn_start = 1'b0;
    cycles(3);

    // Game 3: reach 5 points, then reset mid-game
    btn_start = 1'b1;
    cycles(4);
    btn_start = 1'b0;
    frames(2);
    frames(300);
    chk("g3_score_5", score, 8'd5);
    chk("g3_stop", {7'd0, stop}, 8'd1);
    reset = 1'b0;
    cycles(1);
    chk("g3_rst_score", score, 8'd0);
    chk("g3_rst_best", best, 8'd0);
    chk("g3_rst_load_counter", {7'd0, load_counter}, 8'd1);
    chk("g3_rst_stop", {7'd0, stop}, 8'd0);
    chk("g3_rst_start_machine", {7'd0, start_machine}, 8'd0);
    chk("g3_rst_flash", {7'd0, flash}, 8'd0);
    reset = 1'b1;
    cycles(2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
